// File: rtl/pipe_mac_pkg.sv
// rtl/pipe_mac_pkg.sv - shared widths and FSM state codes for the MAC sequencer
package pipe_mac_pkg;

    localparam int IF_ADDR_W   = 4;
    localparam int FILT_ADDR_W = 4;
    localparam int OUT_CNT_W   = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

endpackage

// File: rtl/pipe_tap_counter.sv
// rtl/pipe_tap_counter.sv - clearable up-counter with terminal-value flag
// Ports: clk_i/rst_ni clock and async active-low reset; clr_i zeroes the count
// (wins over en_i); en_i increments; term_val_i terminal value; cnt_o count;
// term_o high while cnt_o equals term_val_i.
module pipe_tap_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/pipe_mac_sequencer.sv
// rtl/pipe_mac_sequencer.sv - window sequencer driving one pipelined MAC datapath
// Ports: clk_i, rst_ni (async active-low); start_i with filt_len_i/stride_i/
// num_out_i run parameters latched on start; if_count_i IF words available,
// psum_full_i result back-pressure; if_addr_o/filt_addr_o scratchpad reads;
// ld_mult_o, ld_add_o, par_done_o, pipe_stall_o datapath controls; if_pop_o
// releases stride words; psum_valid_o result strobe; busy_o, done_o run status.
module pipe_mac_sequencer
    import pipe_mac_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [FILT_ADDR_W:0]   filt_len_i,
    input  logic [IF_ADDR_W-1:0]   stride_i,
    input  logic [OUT_CNT_W-1:0]   num_out_i,
    input  logic [IF_ADDR_W:0]     if_count_i,
    input  logic                   psum_full_i,
    output logic [IF_ADDR_W-1:0]   if_addr_o,
    output logic [FILT_ADDR_W-1:0] filt_addr_o,
    output logic                   ld_mult_o,
    output logic                   ld_add_o,
    output logic                   par_done_o,
    output logic                   pipe_stall_o,
    output logic                   if_pop_o,
    output logic                   psum_valid_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int CMP_W = IF_ADDR_W + FILT_ADDR_W + 2;

    logic [2:0]             state_q, state_d;
    logic [FILT_ADDR_W:0]   filt_len_q, filt_len_d;
    logic [IF_ADDR_W-1:0]   stride_q, stride_d;
    logic [OUT_CNT_W-1:0]   num_out_q, num_out_d;
    logic [IF_ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                   ld_add_q, psum_valid_q, done_q, done_d;

    logic                   tap_clr, tap_en, tap_term;
    logic [FILT_ADDR_W-1:0] tap_cnt;
    logic                   out_clr, out_term;
    logic [OUT_CNT_W-1:0]   out_cnt;

    logic [CMP_W-1:0]       avail, need_now, need_pop;
    logic                   is_issue;

    pipe_tap_counter #(.W(FILT_ADDR_W)) u_tap_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (tap_clr),
        .en_i       (tap_en),
        .term_val_i (FILT_ADDR_W'(filt_len_q - (FILT_ADDR_W+1)'(1))),
        .cnt_o      (tap_cnt),
        .term_o     (tap_term)
    );

    // Counts finished outputs; it advances on psum_valid, which for output j
    // always lands before output j+1 reaches DRAIN, so out_term is current there.
    pipe_tap_counter #(.W(OUT_CNT_W)) u_out_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (out_clr),
        .en_i       (psum_valid_q),
        .term_val_i (num_out_q - OUT_CNT_W'(1)),
        .cnt_o      (out_cnt),
        .term_o     (out_term)
    );

    // In DRAIN the pop is not yet visible in if_count, so the next window is
    // only issued back-to-back if the count still covers it after the pop.
    assign avail    = CMP_W'(if_count_i);
    assign need_now = CMP_W'(filt_len_q);
    assign need_pop = CMP_W'(filt_len_q) + CMP_W'(stride_q);

    always_comb begin
        state_d    = state_q;
        filt_len_d = filt_len_q;
        stride_d   = stride_q;
        num_out_d  = num_out_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = 1'b0;
        tap_clr    = 1'b0;
        tap_en     = 1'b0;
        out_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // done_q high means the done cycle of the previous run: still busy.
                if (start_i && !done_q) begin
                    filt_len_d = filt_len_i;
                    stride_d   = stride_i;
                    num_out_d  = num_out_i;
                    tap_clr    = 1'b1;
                    out_clr    = 1'b1;
                    if (filt_len_i == '0 || num_out_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (avail >= need_now && !psum_full_i) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tap_en = 1'b1;
                if (tap_term) begin
                    tap_clr = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rd_ptr_d = rd_ptr_q + stride_q;
                if (out_term) begin
                    state_d = S_FIN;
                end else if (avail >= need_pop && !psum_full_i) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            filt_len_q   <= '0;
            stride_q     <= '0;
            num_out_q    <= '0;
            rd_ptr_q     <= '0;
            ld_add_q     <= 1'b0;
            psum_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            filt_len_q   <= filt_len_d;
            stride_q     <= stride_d;
            num_out_q    <= num_out_d;
            rd_ptr_q     <= rd_ptr_d;
            ld_add_q     <= (state_q == S_ISSUE);
            psum_valid_q <= (state_q == S_DRAIN);
            done_q       <= done_d;
        end
    end

    assign is_issue     = (state_q == S_ISSUE);
    assign if_addr_o    = is_issue ? rd_ptr_q + IF_ADDR_W'(tap_cnt) : '0;
    assign filt_addr_o  = is_issue ? tap_cnt : '0;
    assign ld_mult_o    = is_issue;
    assign ld_add_o     = ld_add_q;
    assign par_done_o   = (state_q == S_DRAIN);
    assign if_pop_o     = (state_q == S_DRAIN);
    assign pipe_stall_o = (state_q == S_WAIT);
    assign psum_valid_o = psum_valid_q;
    assign busy_o       = (state_q != S_IDLE) || done_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_pipe_mac_sequencer.sv
// tb/tb_pipe_mac_sequencer.sv - scoreboard bench for pipe_mac_sequencer
module tb_pipe_mac_sequencer;
    import pipe_mac_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   start_i = 1'b0;
    logic [FILT_ADDR_W:0]   filt_len_i = '0;
    logic [IF_ADDR_W-1:0]   stride_i = '0;
    logic [OUT_CNT_W-1:0]   num_out_i = '0;
    logic [IF_ADDR_W:0]     if_count_i = '0;
    logic                   psum_full_i = 1'b0;
    logic [IF_ADDR_W-1:0]   if_addr_o;
    logic [FILT_ADDR_W-1:0] filt_addr_o;
    logic ld_mult_o, ld_add_o, par_done_o, pipe_stall_o, if_pop_o, psum_valid_o, busy_o, done_o;

    always #5 clk_i = ~clk_i;

    pipe_mac_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .filt_len_i(filt_len_i), .stride_i(stride_i), .num_out_i(num_out_i),
        .if_count_i(if_count_i), .psum_full_i(psum_full_i),
        .if_addr_o(if_addr_o), .filt_addr_o(filt_addr_o),
        .ld_mult_o(ld_mult_o), .ld_add_o(ld_add_o), .par_done_o(par_done_o),
        .pipe_stall_o(pipe_stall_o), .if_pop_o(if_pop_o), .psum_valid_o(psum_valid_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    int tests = 0;
    int fails = 0;
    int if_mem[16];
    int filt_mem[16];
    int exp_q[$];
    int addr_log[$];
    int model_ptr = 0;
    int fill = 0;
    int cur_stride = 0;
    int psum_seen = 0;
    bit rand_en = 1'b0;
    int mult_m = 0;
    int acc_m = 0;
    bit par_d1 = 1'b0;
    int idx;
    logic [11:0] m_mult, m_add, m_par, m_pv, m_done, m_stall;
    int e2[4] = '{14, 15, 0, 1};

    task automatic check(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({if_addr_o, filt_addr_o, ld_mult_o, ld_add_o, par_done_o,
                     pipe_stall_o, if_pop_o, psum_valid_o, busy_o, done_o});
    endfunction

    // Expected partial sums straight from the windowing rule: output j reads
    // IF words starting at ptr + j*stride (mod 16) against taps 0..K-1.
    task automatic push_exp(int k, int s, int n);
        if (k == 0 || n == 0) return;
        for (int j = 0; j < n; j++) begin
            int p;
            int sum;
            p = (model_ptr + j * s) % 16;
            sum = 0;
            for (int t = 0; t < k; t++) sum += filt_mem[t] * if_mem[(p + t) % 16];
            exp_q.push_back(sum);
        end
        model_ptr = (model_ptr + n * s) % 16;
    endtask

    // Monitor: behavioural MAC datapath fed by the DUT controls; compares the
    // accumulator against the scoreboard whenever psum_valid is presented.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mult_m = 0;
            acc_m  = 0;
            par_d1 = 1'b0;
        end else begin
            if (psum_valid_o) begin
                psum_seen++;
                if (exp_q.size() == 0) check("psum_unexpected", 1, 0);
                else check("psum_value", acc_m, exp_q.pop_front());
            end
            if (par_d1) check("ld_add_on_clear", int'(ld_add_o), 0);
            if (ld_mult_o) addr_log.push_back(int'(if_addr_o));
            acc_m  = par_d1 ? 0 : (ld_add_o ? acc_m + mult_m : acc_m);
            mult_m = ld_mult_o ? if_mem[if_addr_o] * filt_mem[filt_addr_o] : mult_m;
            par_d1 = par_done_o;
        end
    end

    // One clock: IF count drops by stride one cycle after a pop is seen.
    task automatic cycle();
        bit pop;
        @(negedge clk_i);
        pop = if_pop_o;
        @(posedge clk_i);
        #1;
        if (pop) fill -= cur_stride;
        if (fill < 0) fill = 0;
        if (rand_en) begin
            fill += $urandom_range(0, 2);
            if (fill > 16) fill = 16;
            psum_full_i = ($urandom_range(0, 3) == 0);
        end
        if_count_i = (IF_ADDR_W+1)'(fill);
    endtask

    task automatic set_fill(int f);
        fill = f;
        if_count_i = (IF_ADDR_W+1)'(fill);
    endtask

    task automatic launch(int k, int s, int n);
        push_exp(k, s, n);
        cur_stride = s;
        filt_len_i = (FILT_ADDR_W+1)'(k);
        stride_i   = IF_ADDR_W'(s);
        num_out_i  = OUT_CNT_W'(n);
        psum_seen  = 0;
        start_i    = 1'b1;
        cycle();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(int n, string name);
        int c;
        c = 0;
        while (!done_o && c < 3000) begin
            cycle();
            c++;
        end
        if (!done_o) check({name, "_done_timeout"}, 0, 1);
        else check({name, "_psum_count"}, psum_seen, n);
        cycle();
    endtask

    task automatic wait_mult(string name);
        int c;
        c = 0;
        while (!ld_mult_o && c < 50) begin
            cycle();
            c++;
        end
        check({name, "_first_ld_mult"}, int'(ld_mult_o), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            if_mem[i]   = $urandom_range(0, 255);
            filt_mem[i] = $urandom_range(0, 255);
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", out_vec(), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle();

        // T1: K=3 stride=1 two outputs, timeline relative to first ld_mult.
        set_fill(8);
        launch(3, 1, 2);
        idx = -1;
        m_mult = '0; m_add = '0; m_par = '0; m_pv = '0; m_done = '0; m_stall = '0;
        for (int c = 0; c < 25; c++) begin
            if (idx < 0 && ld_mult_o) idx = 0;
            if (idx >= 0 && idx < 12) begin
                m_mult[idx]  = ld_mult_o;
                m_add[idx]   = ld_add_o;
                m_par[idx]   = par_done_o;
                m_pv[idx]    = psum_valid_o;
                m_done[idx]  = done_o;
                m_stall[idx] = pipe_stall_o;
                idx++;
            end
            cycle();
        end
        check("t1_ld_mult", int'(m_mult), 'h077);
        check("t1_ld_add", int'(m_add), 'h0EE);
        check("t1_par_done", int'(m_par), 'h088);
        check("t1_psum_valid", int'(m_pv), 'h110);
        check("t1_done", int'(m_done), 'h200);
        check("t1_stall", int'(m_stall), 0);

        // T2: move rd_ptr to 14, then a K=4 window must wrap the IF address.
        set_fill(16);
        launch(6, 6, 2);
        wait_done(2, "t2_pre");
        set_fill(16);
        addr_log.delete();
        launch(4, 1, 1);
        wait_done(1, "t2");
        for (int i = 0; i < 4; i++)
            check("t2_if_addr", (addr_log.size() > i) ? addr_log[i] : -1, e2[i]);
        set_fill(16);
        addr_log.delete();
        launch(2, 1, 1);
        wait_done(1, "t2_post");
        check("t2_rd_ptr_after_pop", (addr_log.size() > 0) ? addr_log[0] : -1, 15);

        // T3: too few IF words holds the stall until the count reaches K.
        set_fill(2);
        launch(3, 1, 1);
        for (int i = 0; i < 5; i++) begin
            check("t3_stall_no_loads", int'({pipe_stall_o, ld_mult_o, ld_add_o}), 4);
            cycle();
        end
        set_fill(3);
        cycle();
        check("t3_issue_after_count", int'(ld_mult_o), 1);
        wait_done(1, "t3");

        // T4: psum_full at a boundary blocks; raised mid-window it does not.
        set_fill(16);
        psum_full_i = 1'b1;
        launch(3, 1, 2);
        for (int i = 0; i < 4; i++) begin
            check("t4_full_wait", int'({pipe_stall_o, ld_mult_o, ld_add_o}), 4);
            cycle();
        end
        psum_full_i = 1'b0;
        wait_mult("t4");
        cycle();
        psum_full_i = 1'b1;
        for (int c = 0; c < 20 && !psum_valid_o; c++) cycle();
        check("t4_mid_window_completes", int'(psum_valid_o), 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t4_boundary_wait", int'({pipe_stall_o, ld_mult_o, ld_add_o}), 4);
        end
        psum_full_i = 1'b0;
        wait_done(2, "t4");

        // T5: degenerate runs finish immediately with no loads.
        launch(0, 1, 3);
        check("t5_zero_len_done", int'({done_o, busy_o, ld_mult_o, ld_add_o}), 'b1100);
        cycle();
        check("t5_zero_len_after", int'({done_o, busy_o, ld_mult_o, ld_add_o}), 0);
        launch(3, 1, 0);
        check("t5_zero_out_done", int'({done_o, ld_mult_o}), 'b10);
        cycle();

        // T6: reset in cycle 1 of a window, then a clean run from rd_ptr 0.
        set_fill(16);
        launch(4, 1, 2);
        wait_mult("t6");
        cycle();
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_reset_outputs", out_vec(), 0);
        exp_q.delete();
        model_ptr = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cycle();
        set_fill(16);
        addr_log.delete();
        launch(3, 2, 2);
        wait_done(2, "t6_post");
        check("t6_restart_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);

        // Randomised runs with random refill and psum back-pressure.
        rand_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            int k, s, n;
            k = $urandom_range(1, 16);
            s = $urandom_range(0, (k > 15) ? 15 : k);
            n = $urandom_range(1, 5);
            launch(k, s, n);
            wait_done(n, "rand");
        end
        rand_en = 1'b0;
        psum_full_i = 1'b0;
        cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
